// File: rtl/axi_lite_arb_pkg.sv
// Shared types and helpers for the AXI4-Lite command arbiter.
package axi_lite_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // Index width for n requesters, never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n < 32'd2) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after i_ptr, wrapping.
module rr_arbiter
    import axi_lite_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W   = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_gnt_id,
    output logic               o_any
);

    logic [ID_W-1:0] w_idx;

    // Scan ptr, ptr+1, ... modulo NUM_REQ and keep the first hit.
    always_comb begin
        o_gnt    = '0;
        o_gnt_id = '0;
        o_any    = 1'b0;
        w_idx    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_idx = ID_W'((32'(i_ptr) + k) % NUM_REQ);
            if (!o_any && i_req[w_idx]) begin
                o_any        = 1'b1;
                o_gnt[w_idx] = 1'b1;
                o_gnt_id     = w_idx;
            end
        end
    end

endmodule

// File: rtl/axi_lite_cmd_arbiter.sv
// Round-robin sharing of one AXI4-Lite master command port among NUM_REQ
// requesters, one transaction in flight at a time.
module axi_lite_cmd_arbiter
    import axi_lite_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    localparam int unsigned ID_W   = id_width(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy,
    output logic                      AXI_Start,
    output logic                      AXI_WriteEn,
    output logic [ADDR_W-1:0]         AXI_Addr,
    output logic [DATA_W-1:0]         AXI_WData,
    input  logic [DATA_W-1:0]         AXI_RData,
    input  logic                      AXI_Done
);

    arb_state_t          r_state;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     r_grant_id;
    logic                r_write;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic [NUM_REQ-1:0]  r_rsp_valid;
    logic                r_start;
    logic                r_busy;

    logic [NUM_REQ-1:0]  w_gnt;
    logic [ID_W-1:0]     w_gnt_id;
    logic                w_any;
    logic                w_sel_write;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .i_req    (req_valid),
        .i_ptr    (r_ptr),
        .o_gnt    (w_gnt),
        .o_gnt_id (w_gnt_id),
        .o_any    (w_any)
    );

    assign w_sel_write = req_write[w_gnt_id];
    assign w_sel_addr  = req_addr[32'(w_gnt_id) * ADDR_W +: ADDR_W];
    assign w_sel_wdata = req_wdata[32'(w_gnt_id) * DATA_W +: DATA_W];

    // Accept pulse is combinational so the winner sees it in the arbitration cycle.
    assign req_ready   = (!rst && r_state == IDLE) ? w_gnt : '0;

    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rdata;
    assign grant_id    = r_grant_id;
    assign busy        = r_busy;
    assign AXI_Start   = r_start;
    assign AXI_WriteEn = r_write;
    assign AXI_Addr    = r_addr;
    assign AXI_WData   = r_wdata;

    // Arbitration FSM with command latch, response capture and rotating priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_grant_id  <= '0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_rsp_valid <= '0;
            r_start     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_write    <= w_sel_write;
                        r_addr     <= w_sel_addr;
                        r_wdata    <= w_sel_wdata;
                        r_grant_id <= w_gnt_id;
                        r_start    <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_start <= 1'b0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (AXI_Done) begin
                        r_rdata     <= AXI_RData;
                        r_rsp_valid <= NUM_REQ'(1) << r_grant_id;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    r_rsp_valid <= '0;
                    r_busy      <= 1'b0;
                    r_ptr       <= (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0
                                                                       : r_grant_id + ID_W'(1);
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_cmd_arbiter.sv
// Randomised scoreboard bench for axi_lite_cmd_arbiter with a transaction-level model.
module tb_axi_lite_cmd_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_write;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic [1:0]        grant_id;
    logic              busy;
    logic              AXI_Start;
    logic              AXI_WriteEn;
    logic [AW-1:0]     AXI_Addr;
    logic [DW-1:0]     AXI_WData;
    logic [DW-1:0]     AXI_RData;
    logic              AXI_Done;

    axi_lite_cmd_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .grant_id    (grant_id),
        .busy        (busy),
        .AXI_Start   (AXI_Start),
        .AXI_WriteEn (AXI_WriteEn),
        .AXI_Addr    (AXI_Addr),
        .AXI_WData   (AXI_WData),
        .AXI_RData   (AXI_RData),
        .AXI_Done    (AXI_Done)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic [N-1:0] rdy; bit busy; } cyc_t;
    typedef struct { int cyc; int id; bit w; logic [31:0] a; logic [31:0] d; } cmd_t;
    typedef struct { int cyc; int id; bit w; logic [31:0] rd; } rsp_t;

    cyc_t eq[$];
    cmd_t sq[$];
    rsp_t rq[$];

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Requester-side state (what each client is currently asking for)
    bit          pend[N];
    bit          pw[N];
    logic [31:0] pa[N];
    logic [31:0] pd[N];
    bit          auto_rr[N];
    bit          rand_en = 1'b0;
    bit          drop_en = 1'b0;
    bit          spur_en = 1'b0;
    int          force_lat = 0;
    bit          force_rd_en = 1'b0;
    logic [31:0] force_rdata = '0;

    // Reference model: one transaction at a time, rotating priority pointer
    bit m_active = 1'b0;
    int m_acc_cyc = 0;
    int m_done_cyc = 0;
    int m_ptr = 0;
    int m_cur = 0;
    bit m_w = 1'b0;
    int m_acc_pending = -1;
    int n_accepts = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic new_req(input int i);
        pend[i] = 1'b1;
        pw[i]   = 1'($urandom_range(0, 1));
        pa[i]   = 32'($urandom) & 32'h0000_FFFC;
        pd[i]   = 32'($urandom);
    endtask

    function automatic bit any_pend();
        bit r = 1'b0;
        for (int i = 0; i < N; i++) r |= pend[i];
        return r;
    endfunction

    task automatic drive_reqs();
        for (int i = 0; i < N; i++) begin
            req_valid[i]            = pend[i];
            req_write[i]            = pw[i];
            req_addr[i*AW +: AW]    = pa[i];
            req_wdata[i*DW +: DW]   = pd[i];
        end
    endtask

    // One clock of stimulus plus the model's prediction for that clock.
    task automatic step();
        int c;
        int g;
        logic [N-1:0] rdy;
        bit done;
        logic [31:0] rd;
        bit busy_e;
        @(posedge clk);
        #1;
        c = cyc;
        if (m_active && c >= m_done_cyc + 2) m_active = 1'b0;
        if (m_acc_pending >= 0) begin
            if (auto_rr[m_acc_pending]) new_req(m_acc_pending);
            else pend[m_acc_pending] = 1'b0;
            m_acc_pending = -1;
        end
        for (int i = 0; i < N; i++) begin
            if (rand_en && !pend[i] && $urandom_range(0, 3) == 0) new_req(i);
            else if (drop_en && pend[i] && $urandom_range(0, 15) == 0) pend[i] = 1'b0;
        end
        done = 1'b0;
        rd   = 32'($urandom);
        if (m_active && c == m_done_cyc) begin
            done = 1'b1;
            if (force_rd_en) rd = force_rdata;
            rq.push_back('{cyc: c + 1, id: m_cur, w: m_w, rd: rd});
            m_ptr = (m_cur + 1) % N;
        end else if (spur_en && !(m_active && c >= m_acc_cyc + 2 && c <= m_done_cyc)
                     && $urandom_range(0, 3) == 0) begin
            done = 1'b1;
        end
        rdy = '0;
        g = -1;
        if (!m_active) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (g < 0 && pend[j]) g = j;
            end
        end
        if (g >= 0) begin
            rdy[g] = 1'b1;
            sq.push_back('{cyc: c + 1, id: g, w: pw[g], a: pa[g], d: pd[g]});
            m_active      = 1'b1;
            m_acc_cyc     = c;
            m_cur         = g;
            m_w           = pw[g];
            m_done_cyc    = c + 1 + ((force_lat > 0) ? force_lat : int'($urandom_range(1, 5)));
            m_acc_pending = g;
            n_accepts++;
        end
        busy_e = m_active && (c > m_acc_cyc);
        drive_reqs();
        AXI_Done  = done;
        AXI_RData = rd;
        eq.push_back('{cyc: c, rdy: rdy, busy: busy_e});
        chk_en = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'(0));
        chk({tag, "_grant_id"},  64'(grant_id),  64'(0));
        chk({tag, "_busy"},      64'(busy),      64'(0));
        chk({tag, "_start"},     64'(AXI_Start), 64'(0));
        chk({tag, "_we"},        64'(AXI_WriteEn), 64'(0));
        chk({tag, "_addr"},      64'(AXI_Addr),  64'(0));
        chk({tag, "_wdata"},     64'(AXI_WData), 64'(0));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        chk_en = 1'b0;
        eq.delete();
        sq.delete();
        rq.delete();
        req_valid = '0;
        AXI_Done  = 1'b0;
        #1;
        check_zero("rst");
        req_valid = '1;
        #1;
        chk("rst_req_ready_gated", 64'(req_ready), 64'(0));
        req_valid = '0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            auto_rr[i] = 1'b0;
        end
        m_active = 1'b0;
        m_ptr = 0;
        m_acc_pending = -1;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    task automatic run_idle(input int max_cyc);
        bit ok = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            step();
            if (!m_active && !any_pend()) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout cycle=%0d got=busy expected=idle", cyc);
        end
        step();
        step();
    endtask

    task automatic run_accepts(input int n, input int max_cyc);
        int target = n_accepts + n;
        for (int k = 0; k < max_cyc && n_accepts < target; k++) step();
        if (n_accepts < target) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout cycle=%0d got=%0d expected=%0d", cyc, n_accepts, target);
        end
        for (int i = 0; i < N; i++) begin
            auto_rr[i] = 1'b0;
            if (i != m_acc_pending) pend[i] = 1'b0;
        end
    endtask

    // Monitor: compares DUT outputs with the model's queued expectations.
    cyc_t        mon_e;
    cmd_t        mon_s;
    cmd_t        cur_cmd;
    rsp_t        mon_r;
    bit          mon_es;
    bit          mon_er;
    bit          have_cmd = 1'b0;
    logic [N-1:0] mon_rv;

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            if (eq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL cycle_entry cycle=%0d got=none expected=entry", cyc);
            end else begin
                mon_e = eq.pop_front();
                chk("cycle_stamp", 64'(mon_e.cyc), 64'(cyc));
                chk("req_ready", 64'(req_ready), 64'(mon_e.rdy));
                chk("busy", 64'(busy), 64'(mon_e.busy));
                mon_es = (sq.size() > 0) && (sq[0].cyc == cyc);
                chk("AXI_Start", 64'(AXI_Start), 64'(mon_es));
                if (mon_es) begin
                    mon_s = sq.pop_front();
                    cur_cmd = mon_s;
                    have_cmd = 1'b1;
                    chk("start_grant_id", 64'(grant_id), 64'(mon_s.id));
                    chk("AXI_WriteEn", 64'(AXI_WriteEn), 64'(mon_s.w));
                    chk("AXI_Addr", 64'(AXI_Addr), 64'(mon_s.a));
                    chk("AXI_WData", 64'(AXI_WData), 64'(mon_s.d));
                end else if (mon_e.busy && have_cmd) begin
                    chk("hold_cmd", {31'd0, AXI_WriteEn, AXI_Addr}, {31'd0, cur_cmd.w, cur_cmd.a});
                    chk("hold_wdata", 64'(AXI_WData), 64'(cur_cmd.d));
                end
                mon_er = (rq.size() > 0) && (rq[0].cyc == cyc);
                mon_rv = '0;
                if (mon_er) mon_rv[rq[0].id] = 1'b1;
                chk("rsp_valid", 64'(rsp_valid), 64'(mon_rv));
                if (mon_er) begin
                    mon_r = rq.pop_front();
                    chk("rsp_grant_id", 64'(grant_id), 64'(mon_r.id));
                    if (!mon_r.w) chk("rsp_rdata", 64'(rsp_rdata), 64'(mon_r.rd));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr = '0;
        req_wdata = '0;
        AXI_RData = '0;
        AXI_Done = 1'b0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0;
            pw[i] = 1'b0;
            pa[i] = '0;
            pd[i] = '0;
            auto_rr[i] = 1'b0;
        end
        do_reset();

        // Single read from requester 2
        pend[2] = 1'b1; pw[2] = 1'b0; pa[2] = 32'h0000_0040; pd[2] = 32'h0;
        force_lat = 3; force_rd_en = 1'b1; force_rdata = 32'hDEAD_BEEF;
        run_idle(40);

        // Single write from requester 1
        pend[1] = 1'b1; pw[1] = 1'b1; pa[1] = 32'h0000_0010; pd[1] = 32'h1234_5678;
        force_lat = 4; force_rdata = 32'h0BAD_F00D;
        run_idle(40);
        force_lat = 0; force_rd_en = 1'b0;

        // All requesters continuously asking: eight rotations from ptr 0
        do_reset();
        for (int i = 0; i < N; i++) begin
            auto_rr[i] = 1'b1;
            new_req(i);
        end
        run_accepts(8, 200);
        run_idle(60);

        // Move ptr to 1, then only requesters 0 and 3 compete
        new_req(0);
        run_idle(40);
        auto_rr[0] = 1'b1; auto_rr[3] = 1'b1;
        new_req(0); new_req(3);
        run_accepts(3, 100);
        run_idle(60);

        // Spurious Done while idle
        spur_en = 1'b1;
        repeat (12) step();
        spur_en = 1'b0;

        // Long wait before Done, with spurious Done around it
        new_req(2);
        force_lat = 50;
        run_idle(100);
        force_lat = 0;

        // Random traffic, drops and stray Done pulses
        rand_en = 1'b1; drop_en = 1'b1; spur_en = 1'b1;
        repeat (800) step();
        rand_en = 1'b0; drop_en = 1'b0; spur_en = 1'b0;
        run_idle(100);

        // Leave ptr at 1, then reset during WAIT of requester 1
        new_req(0);
        run_idle(40);
        new_req(1);
        force_lat = 20;
        for (int k = 0; k < 30 && !(m_active && cyc >= m_acc_cyc + 4); k++) step();
        force_lat = 0;
        do_reset();
        new_req(0); new_req(2);
        run_idle(60);

        chk("start_queue_drained", 64'(sq.size()), 64'(0));
        chk("rsp_queue_drained", 64'(rq.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_lite_cmd_arbiter.md
Name: axi_lite_cmd_arbiter

Overview:
Shares one AXI4-Lite master command port (Start/WriteEn/Addr/WData/RData/Done) between NUM_REQ independent requesters.
- Round-robin arbitration; one transaction in flight at a time.
- Latches the winning command and drives the master's command port.
- Waits for Done, then returns read data to the granted requester.
- Sits between on-chip clients (DMA setup, CSR bridge, debug) and the single AXI4-Lite master.

Parameters:
NUM_REQ, 4, number of requesters (legal range 2..16)
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
req_valid  in  NUM_REQ  per-requester command pending; held until req_ready
req_write  in  NUM_REQ  1=write, 0=read, per requester
req_addr  in  NUM_REQ*ADDR_W  requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  requester i at [i*DATA_W +: DATA_W]
req_ready  out  NUM_REQ  one-hot, one-cycle command-accept pulse
rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse
rsp_rdata  out  DATA_W  read data for the completing transaction; held until next completion
grant_id  out  $clog2(NUM_REQ)  index of the current/last granted requester
busy  out  1  high whenever state != IDLE
AXI_Start  out  1  to master: start transaction
AXI_WriteEn  out  1  to master: direction
AXI_Addr  out  ADDR_W  to master: address
AXI_WData  out  DATA_W  to master: write data
AXI_RData  in  DATA_W  from master: read data
AXI_Done  in  1  from master: one-cycle completion pulse

Behaviour:
- Reset:
  - Outputs: all outputs 0.
  - State: IDLE, ptr=0, latched command cleared.
  - Reset mid-transaction: abandon immediately, no rsp_valid. The master shares rst, so no stale Done follows.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid, pick the winner g as the first set bit scanning ptr, ptr+1, ... mod NUM_REQ.
  - Same cycle: req_ready[g]=1 (combinational from registered state and req_valid).
  - Register req_write/addr/wdata of g, set grant_id=g, go ISSUE.
  - With no request, stay in IDLE; req_ready=0.
- ISSUE:
  - AXI_Start=1 for exactly one cycle; AXI_WriteEn/Addr/WData come from the latch. Go WAIT.
- WAIT:
  - AXI_Start=0; Addr/WData/WriteEn stay stable from the latch.
  - On AXI_Done: capture AXI_RData into rsp_rdata (writes also capture; value is don't-care for writes), go RESP.
- RESP:
  - rsp_valid[grant_id]=1 for one cycle.
  - ptr <= (grant_id+1) mod NUM_REQ. Go IDLE.
- AXI_Start is never asserted outside ISSUE. AXI_Done seen in IDLE/ISSUE/RESP is ignored.
- Latency:
  - req accept -> AXI_Start: 1 cycle.
  - AXI_Done -> rsp_valid: 1 cycle.
  - rsp_valid -> next possible req_ready: 1 cycle.
  - The next AXI_Start is therefore ≥3 cycles after a Done, which guarantees the master is back in its IDLE.
- Fairness: a continuously requesting client waits at most NUM_REQ-1 transactions.
- Requests:
  - req_valid deasserting before req_ready is allowed; the request is dropped.
  - Inputs of the granted requester are not sampled after the accept cycle.
- A requester may re-request in the same cycle as its own rsp_valid; it is evaluated in the following IDLE cycle.
- ptr arithmetic wraps: NUM_REQ-1 -> 0, including for non-power-of-2 NUM_REQ.

Decomposition:
- Package axi_lite_arb_pkg:
  - state enum arb_state_t {IDLE, ISSUE, WAIT, RESP}.
  - Localparam functions for ID width ($clog2 with a minimum of 1).
- Sub-module rr_arbiter:
  - Combinational round-robin pick.
  - Inputs: req vector and ptr. Outputs: one-hot grant, grant index, any.
  - Parameterized by NUM_REQ.
- Top holds the FSM, command latch, ptr and rsp_rdata registers.

Test Plan:
- Single read: req_valid[2]=1, addr=0x0000_0040, read. Expect:
  - req_ready[2] pulse; AXI_Start one cycle later with AXI_Addr=0x40, AXI_WriteEn=0.
  - Model Done with RData=0xDEAD_BEEF -> rsp_valid[2] next cycle, rsp_rdata=0xDEADBEEF, grant_id=2.
- Single write: req 1 write addr=0x10, wdata=0x1234_5678. Expect:
  - AXI_WriteEn=1, AXI_WData=0x12345678 stable through WAIT.
  - rsp_valid[1] exactly one cycle after Done.
- Round-robin: all 4 req_valid held high for 8 transactions -> grant order 0,1,2,3,0,1,2,3; each rsp_valid is one-hot and matches the grant.
- Skip idle requesters: only req 0 and 3 active, ptr starts at 1 -> grant 3 then 0 then 3; no grant to 1 or 2.
- Spurious Done in IDLE: no rsp_valid and no state change. A long WAIT (50 cycles before Done) keeps AXI_Start=0 and busy=1 throughout.
- Reset in WAIT: assert rst -> all outputs 0 immediately, no rsp_valid. After release, the pending req 0 is granted with ptr=0.
